// File: rtl/fetch_queue_if.sv
// Fetch queue signal bundle: backend redirect, imem request/response and instruction head.
// The master modport is the fetch queue itself; slave is the surrounding environment.
interface fetch_queue_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic [63:0] flush_order;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_rqst;
    logic        imem_ready;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [63:0] inst_order;

    modport master (
        input  flush, flush_pc, flush_order, imem_ready, imem_resp, imem_rdata, inst_ready,
        output imem_addr, imem_rmask, imem_rqst, inst_valid, inst_data, inst_pc, inst_order
    );

    modport slave (
        output flush, flush_pc, flush_order, imem_ready, imem_resp, imem_rdata, inst_ready,
        input  imem_addr, imem_rmask, imem_rqst, inst_valid, inst_data, inst_pc, inst_order
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential imem requests, in-order tag tracking, DEPTH-entry buffer.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response to the head when the queue is empty.
module fetch_queue #(
    parameter logic [31:0] PC_RESET        = 32'h6000_0000,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master ifc
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;
    typedef logic [CntW:0]   sum_t;

    logic [31:0] pc_q, pc_d;
    logic [63:0] order_q, order_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        drop_q, drop_d;
    ptr_t        qhd_q, qhd_d, qtl_q, qtl_d;
    ptr_t        thd_q, thd_d, ttl_q, ttl_d;

    logic [31:0] q_data_mem    [DEPTH];
    logic [31:0] q_pc_mem      [DEPTH];
    logic [63:0] q_order_mem   [DEPTH];
    logic [31:0] tag_pc_mem    [DEPTH];
    logic [63:0] tag_order_mem [DEPTH];

    logic rqst, accept, resp_vld, live_resp, bypass, push, pop;

    always_comb begin
        // Issue only while every in-flight request (dropped ones included) has a queue slot.
        rqst = rst && !ifc.flush && (outst_q < cnt_t'(MAX_OUTSTANDING)) &&
               ((sum_t'(count_q) + sum_t'(outst_q)) < sum_t'(DEPTH));
        accept    = rqst && ifc.imem_ready;
        resp_vld  = ifc.imem_resp && (outst_q != '0);
        live_resp = resp_vld && (drop_q == '0) && !ifc.flush;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass    = live_resp && (count_q == '0);
`else
        bypass    = 1'b0;
`endif
        pop  = rst && !ifc.flush && (count_q != '0) && ifc.inst_ready;
        push = live_resp && !(bypass && ifc.inst_ready);

        ifc.imem_rqst  = rqst;
        ifc.imem_rmask = rqst ? 4'hF : 4'h0;
        ifc.imem_addr  = rst ? pc_q : PC_RESET;
        ifc.inst_valid = rst && !ifc.flush && ((count_q != '0) || bypass);
        if (bypass) begin
            ifc.inst_data  = ifc.imem_rdata;
            ifc.inst_pc    = tag_pc_mem[thd_q];
            ifc.inst_order = tag_order_mem[thd_q];
        end else begin
            ifc.inst_data  = q_data_mem[qhd_q];
            ifc.inst_pc    = q_pc_mem[qhd_q];
            ifc.inst_order = q_order_mem[qhd_q];
        end
    end

    always_comb begin
        pc_d    = pc_q;
        order_d = order_q;
        count_d = count_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        qhd_d   = qhd_q;
        qtl_d   = qtl_q;
        thd_d   = thd_q;
        ttl_d   = ttl_q;
        if (ifc.flush) begin
            pc_d    = ifc.flush_pc;
            order_d = ifc.flush_order;
            count_d = '0;
            qhd_d   = '0;
            qtl_d   = '0;
            thd_d   = '0;
            ttl_d   = '0;
            outst_d = outst_q - cnt_t'(resp_vld);
            // Everything still in flight belongs to the old stream.
            drop_d  = outst_d;
        end else begin
            if (accept) begin
                pc_d    = pc_q + 32'd4;
                order_d = order_q + 64'd1;
                ttl_d   = ttl_q + ptr_t'(1);
            end
            if (live_resp) thd_d = thd_q + ptr_t'(1);
            if (push)      qtl_d = qtl_q + ptr_t'(1);
            if (pop)       qhd_d = qhd_q + ptr_t'(1);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
            outst_d = outst_q + cnt_t'(accept) - cnt_t'(resp_vld);
            if (resp_vld && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= PC_RESET;
            order_q <= '0;
            count_q <= '0;
            outst_q <= '0;
            drop_q  <= '0;
            qhd_q   <= '0;
            qtl_q   <= '0;
            thd_q   <= '0;
            ttl_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            order_q <= order_d;
            count_q <= count_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            qhd_q   <= qhd_d;
            qtl_q   <= qtl_d;
            thd_q   <= thd_d;
            ttl_q   <= ttl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_pc_mem[ttl_q]    <= pc_q;
            tag_order_mem[ttl_q] <= order_q;
        end
        if (push) begin
            q_data_mem[qtl_q]  <= ifc.imem_rdata;
            q_pc_mem[qtl_q]    <= tag_pc_mem[thd_q];
            q_order_mem[qtl_q] <= tag_order_mem[thd_q];
        end
    end

    // A response with nothing in flight is ignored above; flag it in simulation.
    resp_without_request: assert property (@(posedge clk) disable iff (!rst)
        !(ifc.imem_resp && (outst_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand sequences for flush/wrap/fill corners,
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;
    localparam logic [31:0] PcReset = 32'h6000_0000;
    localparam int Depth  = 8;
    localparam int MaxOut = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit Byp        = 1'b1;
    localparam int FirstValid = 1;
`else
    localparam bit Byp        = 1'b0;
    localparam int FirstValid = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if ifc ();

    fetch_queue #(
        .PC_RESET       (PcReset),
        .DEPTH          (Depth),
        .MAX_OUTSTANDING(MaxOut)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifc(ifc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drv(input logic fl, input logic rdy, input logic rsp, input logic [31:0] rd,
                       input logic ir);
        ifc.flush      = fl;
        ifc.imem_ready = rdy;
        ifc.imem_resp  = rsp;
        ifc.imem_rdata = rd;
        ifc.inst_ready = ir;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        ifc.flush_pc    = 32'h0;
        ifc.flush_order = 64'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_rqst", ifc.imem_rqst, 1'b0);
            check("rst_rmask", ifc.imem_rmask, 4'h0);
            check("rst_valid", ifc.inst_valid, 1'b0);
            check("rst_addr", ifc.imem_addr, PcReset);
            next_cycle();
        end
        rst = 1'b1;
    endtask

    typedef struct {
        logic        flush;
        logic [31:0] fpc;
        logic [63:0] ford;
        logic        ready;
        logic        resp;
        logic [31:0] rdata;
        logic        iready;
        logic        e_rqst;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_pc;
        logic [63:0] e_order;
    } vec_t;

    function automatic vec_t mk(logic fl, logic [31:0] fpc, logic [63:0] ford, logic rdy,
                                logic rsp, logic [31:0] rd, logic ir, logic er,
                                logic [31:0] ea, logic ev, logic [31:0] ed, logic [31:0] ep,
                                logic [63:0] eo);
        return '{fl, fpc, ford, rdy, rsp, rd, ir, er, ea, ev, ed, ep, eo};
    endfunction

    typedef struct packed {logic [31:0] pc; logic [63:0] order; logic live;} req_t;
    typedef struct packed {logic [31:0] data; logic [31:0] pc; logic [63:0] order;} ins_t;

    req_t        pend[$];
    ins_t        fq[$];
    logic [31:0] m_pc;
    logic [63:0] m_order;

    initial begin
        vec_t        tbl [14];
        int          npend, acc, k;
        logic        a, r, exp_rqst, exp_valid, byp;
        logic [31:0] tmp;
        ins_t        head;
        req_t        rq;

        tbl[0]  = mk(0, 0, 0, 1, 0, 32'h0, 1,  1, 32'h6000_0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 1, 32'h13, 1, 1, 32'h6000_0004, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 1, 32'h93, 1, 1, 32'h6000_0008, 1, 32'h13, 32'h6000_0000, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 32'h113, 0, 1, 32'h6000_000C, 1, 32'h93, 32'h6000_0004, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h6000_000C, 1, 32'h93, 32'h6000_0004, 1);
        tbl[5]  = mk(1, 32'h6000_1000, 100, 1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 0, 32'h0, 1, 1, 32'h6000_1000, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0, 32'h0, 1, 1, 32'h6000_1004, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 32'h6000_2000, 200, 1, 1, 32'hDEAD, 1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 32'hBAD, 1, 1, 32'h6000_2000, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 32'h33, 1, 1, 32'h6000_2004, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 32'h0, 1, 1, 32'h6000_2004, 1, 32'h33, 32'h6000_2000, 200);
        tbl[13] = mk(0, 0, 0, 0, 0, 32'h0, 1, 1, 32'h6000_2004, 0, 0, 0, 0);

        apply_reset();
`ifndef FETCH_QUEUE_BYPASS_EN
        for (int i = 0; i < 14; i++) begin
            drv(tbl[i].flush, tbl[i].ready, tbl[i].resp, tbl[i].rdata, tbl[i].iready);
            ifc.flush_pc    = tbl[i].fpc;
            ifc.flush_order = tbl[i].ford;
            @(negedge clk);
            check($sformatf("vec%0d_rqst", i), ifc.imem_rqst, tbl[i].e_rqst);
            check($sformatf("vec%0d_rmask", i), ifc.imem_rmask, tbl[i].e_rqst ? 4'hF : 4'h0);
            if (tbl[i].e_rqst) check($sformatf("vec%0d_addr", i), ifc.imem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_valid", i), ifc.inst_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d_data", i), ifc.inst_data, tbl[i].e_data);
                check($sformatf("vec%0d_pc", i), ifc.inst_pc, tbl[i].e_pc);
                check($sformatf("vec%0d_order", i), ifc.inst_order, tbl[i].e_order);
            end
            next_cycle();
        end
`endif

        // Steady stream: one instruction per cycle once the pipe fills.
        apply_reset();
        npend = 0;
        k = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            drv(1'b0, 1'b1, npend > 0, 32'h100 + cyc, 1'b1);
            @(negedge clk);
            check("steady_valid", ifc.inst_valid, cyc >= FirstValid);
            if (ifc.inst_valid) begin
                check("steady_pc", ifc.inst_pc, PcReset + 32'(4 * k));
                check("steady_order", ifc.inst_order, 64'(k));
                k++;
            end
            a = ifc.imem_rqst && ifc.imem_ready;
            r = ifc.imem_resp;
            next_cycle();
            npend = npend + int'(a) - int'(r);
        end

        // Fill with the consumer stalled, then free exactly one slot.
        apply_reset();
        npend = 0;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            drv(1'b0, 1'b1, npend > 0, $urandom, 1'b0);
            @(negedge clk);
            a = ifc.imem_rqst && ifc.imem_ready;
            r = ifc.imem_resp;
            next_cycle();
            npend = npend + int'(a) - int'(r);
            acc += int'(a);
        end
        check("fill_accepts", 64'(acc), 64'd8);
        drv(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("full_rqst", ifc.imem_rqst, 1'b0);
        check("full_valid", ifc.inst_valid, 1'b1);
        next_cycle();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            drv(1'b0, 1'b1, npend > 0, $urandom, 1'b0);
            @(negedge clk);
            a = ifc.imem_rqst && ifc.imem_ready;
            r = ifc.imem_resp;
            next_cycle();
            npend = npend + int'(a) - int'(r);
            acc += int'(a);
        end
        check("refill_accepts", 64'(acc), 64'd1);

        // Flush with two in flight, coinciding with a response and a ready consumer.
        apply_reset();
        drv(0, 1, 0, 0, 0); next_cycle();
        drv(0, 1, 0, 0, 0); next_cycle();
        drv(0, 1, 1, 32'hAAAA, 0);
        @(negedge clk); check("cap_rqst", ifc.imem_rqst, 1'b0); next_cycle();
        drv(0, 1, 0, 0, 0);
        @(negedge clk);
        check("pre_flush_addr", ifc.imem_addr, 32'h6000_0008);
        check("pre_flush_valid", ifc.inst_valid, 1'b1);
        next_cycle();
        ifc.flush_pc = 32'h6000_1000;
        ifc.flush_order = 64'd100;
        drv(1, 1, 1, 32'hBBBB, 1);
        @(negedge clk);
        check("flush_valid", ifc.inst_valid, 1'b0);
        check("flush_rqst", ifc.imem_rqst, 1'b0);
        next_cycle();
        drv(0, 1, 0, 0, 1);
        @(negedge clk);
        check("post_flush_rqst", ifc.imem_rqst, 1'b1);
        check("post_flush_addr", ifc.imem_addr, 32'h6000_1000);
        check("post_flush_valid", ifc.inst_valid, 1'b0);
        next_cycle();
        drv(0, 0, 1, 32'hCCCC, 1);
        @(negedge clk); check("dropped_valid", ifc.inst_valid, 1'b0); next_cycle();
        drv(0, 0, 1, 32'hDDDD, 0);
        @(negedge clk); check("live_resp_valid", ifc.inst_valid, Byp); next_cycle();
        drv(0, 0, 0, 0, 1);
        @(negedge clk);
        check("redirect_valid", ifc.inst_valid, 1'b1);
        check("redirect_data", ifc.inst_data, 32'hDDDD);
        check("redirect_pc", ifc.inst_pc, 32'h6000_1000);
        check("redirect_order", ifc.inst_order, 64'd100);
        next_cycle();
        @(negedge clk); check("redirect_drained", ifc.inst_valid, 1'b0); next_cycle();

        // PC and order wrap-around.
        apply_reset();
        ifc.flush_pc = 32'hFFFF_FFFC;
        ifc.flush_order = 64'hFFFF_FFFF_FFFF_FFFF;
        drv(1, 0, 0, 0, 0); next_cycle();
        drv(0, 1, 0, 0, 0);
        @(negedge clk); check("wrap_addr0", ifc.imem_addr, 32'hFFFF_FFFC); next_cycle();
        @(negedge clk); check("wrap_addr1", ifc.imem_addr, 32'h0); next_cycle();
        drv(0, 0, 1, 32'h1111, 0); next_cycle();
        drv(0, 0, 1, 32'h2222, 0); next_cycle();
        drv(0, 0, 0, 0, 1);
        @(negedge clk);
        check("wrap_pc0", ifc.inst_pc, 32'hFFFF_FFFC);
        check("wrap_order0", ifc.inst_order, 64'hFFFF_FFFF_FFFF_FFFF);
        next_cycle();
        @(negedge clk);
        check("wrap_pc1", ifc.inst_pc, 32'h0);
        check("wrap_order1", ifc.inst_order, 64'h0);
        check("wrap_data1", ifc.inst_data, 32'h2222);
        next_cycle();

        // Response-to-head latency on an empty queue.
        apply_reset();
        drv(0, 1, 0, 0, 0); next_cycle();
        drv(0, 0, 1, 32'h13, 0);
        @(negedge clk);
        check("lat_valid_same", ifc.inst_valid, Byp);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("lat_bypass_data", ifc.inst_data, 32'h13);
`endif
        next_cycle();
        drv(0, 0, 0, 0, 0);
        @(negedge clk);
        check("lat_valid_next", ifc.inst_valid, 1'b1);
        check("lat_data_next", ifc.inst_data, 32'h13);
        next_cycle();

        // Randomized traffic against the reference model.
        apply_reset();
        pend.delete();
        fq.delete();
        m_pc = PcReset;
        m_order = 64'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tmp = $urandom;
            ifc.flush_pc    = {tmp[31:2], 2'b00};
            ifc.flush_order = {$urandom, $urandom};
            drv($urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
                (pend.size() > 0) && ($urandom_range(0, 9) < 6), $urandom,
                $urandom_range(0, 9) < 6);
            @(negedge clk);
            exp_rqst = !ifc.flush && (pend.size() < MaxOut) && (fq.size() + pend.size() < Depth);
            byp = Byp && ifc.imem_resp && !ifc.flush && (fq.size() == 0) && pend[0].live;
            exp_valid = !ifc.flush && ((fq.size() > 0) || byp);
            check("rnd_rqst", ifc.imem_rqst, exp_rqst);
            if (exp_rqst) check("rnd_addr", ifc.imem_addr, m_pc);
            check("rnd_valid", ifc.inst_valid, exp_valid);
            if (exp_valid) begin
                head = (fq.size() > 0) ? fq[0] : '{ifc.imem_rdata, pend[0].pc, pend[0].order};
                check("rnd_data", ifc.inst_data, head.data);
                check("rnd_pc", ifc.inst_pc, head.pc);
                check("rnd_order", ifc.inst_order, head.order);
            end
            if (ifc.imem_resp) begin
                rq = pend.pop_front();
                if (rq.live && !ifc.flush) fq.push_back('{ifc.imem_rdata, rq.pc, rq.order});
            end
            if (exp_valid && ifc.inst_ready) void'(fq.pop_front());
            if (ifc.flush) begin
                foreach (pend[i]) pend[i].live = 1'b0;
                fq.delete();
                m_pc = ifc.flush_pc;
                m_order = ifc.flush_order;
            end else if (exp_rqst && ifc.imem_ready) begin
                pend.push_back('{m_pc, m_order, 1'b1});
                m_pc = m_pc + 32'd4;
                m_order = m_order + 64'd1;
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_RESET, default 32'h60000000, PC loaded on reset.
REQ-002 Parameter DEPTH, default 8, instruction-queue entries; power of two, >= 2.
REQ-003 Parameter MAX_OUTSTANDING, default 2, maximum accepted imem requests awaiting response; range 1..DEPTH.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  redirect request from backend.
REQ-007 flush_pc  input  32  redirect PC.
REQ-008 flush_order  input  64  redirect instruction order.
REQ-009 imem_addr  output  32  request address; equals current PC.
REQ-010 imem_rmask  output  4  4'hF when imem_rqst is high, else 4'h0.
REQ-011 imem_rqst  output  1  request valid.
REQ-012 imem_ready  input  1  memory accepts the request this cycle.
REQ-013 imem_resp  input  1  response valid; responses return in request order.
REQ-014 imem_rdata  input  32  instruction word with imem_resp.
REQ-015 inst_valid  output  1  queue head valid.
REQ-016 inst_ready  input  1  consumer takes the head.
REQ-017 inst_data, inst_pc, inst_order  output  32/32/64  head instruction, PC, order.

Function
REQ-018 imem_rqst SHALL be high iff rst high, flush low, outstanding < MAX_OUTSTANDING, and count + outstanding < DEPTH.
REQ-019 Request accepted (imem_rqst & imem_ready): PC += 4 (mod 2^32), order += 1 (mod 2^64), {PC, order} pushed to pending tag FIFO, outstanding += 1.
REQ-020 Unaccepted request SHALL hold imem_addr stable until accepted or flushed.
REQ-021 imem_resp with drop_cnt == 0: pop pending tag; write {imem_rdata, tag PC, tag order} to queue tail; visible on inst_valid the next cycle.
REQ-022 imem_resp with drop_cnt > 0: discard response, drop_cnt -= 1, outstanding -= 1.
REQ-023 inst_valid & inst_ready: pop head; push and pop in same cycle SHALL leave count unchanged, including when full.
REQ-024 Queue SHALL never overflow; REQ-018 reservation guarantees a slot for every live response.
REQ-025 flush: PC <= flush_pc, order <= flush_order, queue and tag FIFO emptied, drop_cnt <= outstanding minus any response in the same cycle; no request issued in the flush cycle.
REQ-026 inst_valid SHALL be forced low combinationally while flush is high; no dequeue occurs that cycle.
REQ-027 Issue resumes the cycle after flush, even while drop_cnt > 0; outstanding cap counts dropped requests.
REQ-028 Back-to-back flushes: last flush wins; drop_cnt recomputed each flush.
REQ-029 imem_resp with outstanding == 0 SHALL be ignored and flagged by a simulation assertion.
REQ-030 Steady state: one instruction per cycle when imem returns one response per cycle and inst_ready is held high.

Reset
REQ-031 rst low at a clock edge: PC = PC_RESET, order = 0, count = 0, outstanding = 0, drop_cnt = 0, tag FIFO empty.
REQ-032 Outputs while in reset: imem_rqst = 0, imem_rmask = 0, inst_valid = 0, imem_addr = PC_RESET.
REQ-033 Reset mid-operation SHALL abandon in-flight requests; responses arriving after reset with outstanding == 0 fall under REQ-029.

Configuration
REQ-034 Macro FETCH_QUEUE_BYPASS_EN defined: when queue empty, imem_resp live, and flush low, head outputs SHALL present imem_rdata/tag combinationally with inst_valid high the same cycle; if inst_ready is high the entry is not written.
REQ-035 Macro undefined: responses always go through the queue; minimum response-to-inst_valid latency one cycle.

Verification
REQ-036 Reset release, imem_ready=1, resp one cycle later, inst_ready=1 -> addresses 0x60000000, 0x60000004, ... ; inst_order 0,1,2,...; one instruction per cycle after fill.
REQ-037 inst_ready=0, DEPTH=8 -> exactly 8 requests accepted, then imem_rqst low; one dequeue -> exactly one new request.
REQ-038 Two requests outstanding, flush to 0x60001000/order 100 -> both responses dropped; next delivered inst_pc 0x60001000, inst_order 100.
REQ-039 Flush in same cycle as response and inst_ready -> response dropped, no dequeue, inst_valid low, drop_cnt = 1.
REQ-040 PC = 0xFFFFFFFC, order = 2^64-1 -> next request address 0x00000000, order 0.
REQ-041 With FETCH_QUEUE_BYPASS_EN: empty queue, response 0x00000013 -> inst_valid high, inst_data 0x00000013 same cycle; without macro, one cycle later.
